// File: rtl/h_tube_regif_if.sv
// Host bus and FIFO-quad signal bundle for h_tube_regif.
// master = host/FIFO side driving inputs, slave = the register interface.
interface h_tube_regif_if;
  logic       h_cs_b;
  logic       h_rdnw;
  logic [2:0] h_addr;
  logic [7:0] h_wdata;
  logic [7:0] h_rdata;
  logic [7:0] ph_data;
  logic [3:0] ph_data_available;
  logic [3:0] ph_select;
  logic       ph_rd;
  logic [3:0] hp_not_full;
  logic [3:0] hp_select;
  logic       hp_wr;
  logic [7:0] hp_data;
  logic [6:0] flags;
  logic       fifo_rst;
  logic       h_irq_b;

  modport master (
    output h_cs_b, h_rdnw, h_addr, h_wdata, ph_data, ph_data_available, hp_not_full,
    input  h_rdata, ph_select, ph_rd, hp_select, hp_wr, hp_data, flags, fifo_rst, h_irq_b
  );

  modport slave (
    input  h_cs_b, h_rdnw, h_addr, h_wdata, ph_data, ph_data_available, hp_not_full,
    output h_rdata, ph_select, ph_rd, hp_select, hp_wr, hp_data, flags, fifo_rst, h_irq_b
  );
endinterface

// File: rtl/h_tube_regif.sv
// Tube host-side register interface: decodes host accesses into FIFO strobes and flag updates.
// Optional macro TUBE_HOST_IRQ_EN enables the host interrupt; otherwise h_irq_b is tied high.
module h_tube_regif (
  input logic          h_phi2,
  input logic          h_rst,
  h_tube_regif_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_HOLD} state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_cs_q_b;
  logic [2:0] r_addr;
  logic       r_rdnw;
  logic [7:0] r_rdata;
  logic [7:0] r_hp_data;
  logic [6:0] r_flags;
  logic       w_fall;
  logic [1:0] w_k;
  logic [3:0] w_onehot;
  logic [3:0] w_ph_select;
  logic       w_ph_rd;
  logic [3:0] w_hp_select;
  logic       w_hp_wr;

  // Reset value 0 means a select held low through reset release is not an edge
  assign w_fall   = r_cs_q_b & ~bus.h_cs_b;
  assign w_k      = r_addr[2:1];
  assign w_onehot = 4'b0001 << w_k;

  always_ff @(posedge h_phi2 or posedge h_rst) begin
    if (h_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_ph_select = 4'b0000;
    w_ph_rd     = 1'b0;
    w_hp_select = 4'b0000;
    w_hp_wr     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) w_next = S_ACCESS;
      end
      S_ACCESS: begin
        w_next      = S_HOLD;
        w_ph_select = w_onehot;
        if (r_rdnw && r_addr[0])
          w_ph_rd = bus.ph_data_available[w_k];
        if (!r_rdnw && r_addr[0] && bus.hp_not_full[w_k]) begin
          w_hp_select = w_onehot;
          w_hp_wr     = 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.h_cs_b) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge h_phi2 or posedge h_rst) begin
    if (h_rst) begin
      r_cs_q_b  <= 1'b0;
      r_addr    <= 3'd0;
      r_rdnw    <= 1'b0;
      r_rdata   <= 8'h00;
      r_hp_data <= 8'h00;
      r_flags   <= 7'h00;
    end else begin
      r_cs_q_b <= bus.h_cs_b;
      if (r_state == S_IDLE && w_fall) begin
        r_addr    <= bus.h_addr;
        r_rdnw    <= bus.h_rdnw;
        r_hp_data <= bus.h_wdata;
      end
      if (r_state == S_ACCESS) begin
        if (r_rdnw) begin
          if (r_addr[0]) r_rdata <= bus.ph_data;
          else r_rdata <= {bus.ph_data_available[w_k], bus.hp_not_full[w_k], r_flags[5:0]};
        end else if (r_addr == 3'd0) begin
          // Bit 7 is the value written to every flag whose mask bit is set
          for (int i = 0; i < 7; i++)
            if (r_hp_data[i]) r_flags[i] <= r_hp_data[7];
        end
      end
    end
  end

`ifdef TUBE_HOST_IRQ_EN
  logic r_irq_b;
  always_ff @(posedge h_phi2 or posedge h_rst) begin
    if (h_rst) r_irq_b <= 1'b1;
    else       r_irq_b <= ~(r_flags[1] & bus.ph_data_available[3]);
  end
  assign bus.h_irq_b = r_irq_b;
`else
  assign bus.h_irq_b = 1'b1;
`endif

  assign bus.h_rdata   = r_rdata;
  assign bus.hp_data   = r_hp_data;
  assign bus.flags     = r_flags;
  assign bus.fifo_rst  = r_flags[6];
  assign bus.ph_select = w_ph_select;
  assign bus.ph_rd     = w_ph_rd;
  assign bus.hp_select = w_hp_select;
  assign bus.hp_wr     = w_hp_wr;

endmodule

// File: tb/tb_h_tube_regif.sv
// Scoreboard bench for h_tube_regif: directed host accesses push expectations, a monitor checks them.
module tb_h_tube_regif;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  h_tube_regif_if bus();
  h_tube_regif dut (.h_phi2(clk), .h_rst(rst), .bus(bus.slave));

`ifdef TUBE_HOST_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0] ph_sel;
    logic       ph_rd;
    logic [3:0] hp_sel;
    logic       hp_wr;
    logic [7:0] hp_data;
    logic [7:0] rdata;
    logic [6:0] flags;
  } exp_t;

  exp_t q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] ps, input logic pr, input logic [3:0] hs,
                              input logic hw, input logic [7:0] hd, input logic [7:0] rd,
                              input logic [6:0] fl);
    exp_t e;
    e.ph_sel = ps; e.ph_rd = pr; e.hp_sel = hs; e.hp_wr = hw;
    e.hp_data = hd; e.rdata = rd; e.flags = fl;
    return e;
  endfunction

  // Monitor: one record per ACCESS cycle, strobes checked mid-cycle, results after edge N+1
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (bus.ph_select != 4'b0000) begin
        if (q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_access: ph_select %b with empty queue", bus.ph_select);
        end else begin
          e = q.pop_front();
          chk("ph_select", {28'd0, bus.ph_select}, {28'd0, e.ph_sel});
          chk("ph_rd",     {31'd0, bus.ph_rd},     {31'd0, e.ph_rd});
          chk("hp_select", {28'd0, bus.hp_select}, {28'd0, e.hp_sel});
          chk("hp_wr",     {31'd0, bus.hp_wr},     {31'd0, e.hp_wr});
          chk("hp_data",   {24'd0, bus.hp_data},   {24'd0, e.hp_data});
          @(posedge clk); #1;
          chk("h_rdata",   {24'd0, bus.h_rdata},   {24'd0, e.rdata});
          chk("flags",     {25'd0, bus.flags},     {25'd0, e.flags});
          chk("fifo_rst",  {31'd0, bus.fifo_rst},  {31'd0, e.flags[6]});
        end
      end else if (bus.ph_rd || bus.hp_wr || bus.hp_select != 4'b0000) begin
        n_cmp++; n_fail++;
        $display("FAIL stray_strobe: ph_rd %b hp_wr %b hp_select %b", bus.ph_rd, bus.hp_wr, bus.hp_select);
      end
    end
  end

  task automatic access(input logic [2:0] a, input logic rd, input logic [7:0] wd,
                        input int low, input exp_t e);
    q.push_back(e);
    @(posedge clk); #2;
    bus.h_addr = a; bus.h_rdnw = rd; bus.h_wdata = wd; bus.h_cs_b = 1'b0;
    repeat (low) @(posedge clk);
    #2 bus.h_cs_b = 1'b1;
    @(posedge clk); #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.h_cs_b = 1'b0; bus.h_rdnw = 1'b1; bus.h_addr = 3'd0; bus.h_wdata = 8'h00;
    bus.ph_data = 8'h00; bus.ph_data_available = 4'b0000; bus.hp_not_full = 4'b0000;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    // Select held low across reset release: monitor flags any access here
    repeat (4) @(posedge clk);
    #1;
    chk("rst_h_rdata",   {24'd0, bus.h_rdata},   32'h00);
    chk("rst_hp_data",   {24'd0, bus.hp_data},   32'h00);
    chk("rst_flags",     {25'd0, bus.flags},     32'h00);
    chk("rst_fifo_rst",  {31'd0, bus.fifo_rst},  32'h0);
    chk("rst_ph_select", {28'd0, bus.ph_select}, 32'h0);
    chk("rst_hp_select", {28'd0, bus.hp_select}, 32'h0);
    chk("rst_strobes",   {30'd0, bus.ph_rd, bus.hp_wr}, 32'h0);
    chk("rst_irq_b",     {31'd0, bus.h_irq_b},   32'h1);
    #1 bus.h_cs_b = 1'b1;
    @(posedge clk); #2;

    // Data read with data present, then from an empty register (stale byte)
    bus.ph_data_available = 4'b0001; bus.ph_data = 8'hA5;
    access(3'd1, 1'b1, 8'h00, 5, mk(4'b0001, 1'b1, 4'b0000, 1'b0, 8'h00, 8'hA5, 7'h00));
    bus.ph_data_available = 4'b0000; bus.ph_data = 8'h5A;
    access(3'd1, 1'b1, 8'h00, 5, mk(4'b0001, 1'b0, 4'b0000, 1'b0, 8'h00, 8'h5A, 7'h00));

    // Control writes and status read
    access(3'd0, 1'b0, 8'h83, 2, mk(4'b0001, 1'b0, 4'b0000, 1'b0, 8'h83, 8'h5A, 7'h03));
    access(3'd0, 1'b0, 8'h01, 2, mk(4'b0001, 1'b0, 4'b0000, 1'b0, 8'h01, 8'h5A, 7'h02));
    bus.ph_data_available = 4'b0001; bus.hp_not_full = 4'b0000;
    access(3'd0, 1'b1, 8'h00, 3, mk(4'b0001, 1'b0, 4'b0000, 1'b0, 8'h00, 8'h82, 7'h02));

    // Data write with space, then to a full register
    bus.hp_not_full = 4'b1000;
    access(3'd7, 1'b0, 8'h3C, 2, mk(4'b1000, 1'b0, 4'b1000, 1'b1, 8'h3C, 8'h82, 7'h02));
    bus.hp_not_full = 4'b0000;
    access(3'd7, 1'b0, 8'h3C, 2, mk(4'b1000, 1'b0, 4'b0000, 1'b0, 8'h3C, 8'h82, 7'h02));

    // Status of register 2 and ignored control write to address 2
    bus.ph_data_available = 4'b0100; bus.hp_not_full = 4'b0100;
    access(3'd4, 1'b1, 8'h00, 2, mk(4'b0100, 1'b0, 4'b0000, 1'b0, 8'h00, 8'hC2, 7'h02));
    access(3'd2, 1'b0, 8'hFF, 2, mk(4'b0010, 1'b0, 4'b0000, 1'b0, 8'hFF, 8'hC2, 7'h02));

    // Interrupt: clear I, set I, raise data on register 3, then clear I
    bus.ph_data_available = 4'b0000;
    access(3'd0, 1'b0, 8'h02, 2, mk(4'b0001, 1'b0, 4'b0000, 1'b0, 8'h02, 8'hC2, 7'h00));
    access(3'd0, 1'b0, 8'h82, 2, mk(4'b0001, 1'b0, 4'b0000, 1'b0, 8'h82, 8'hC2, 7'h02));
    bus.ph_data_available = 4'b1000;
    chk("irq_lag", {31'd0, bus.h_irq_b}, 32'h1);
    @(posedge clk); #1;
    chk("irq_assert", {31'd0, bus.h_irq_b}, {31'd0, ~IRQ_EN});
    access(3'd0, 1'b0, 8'h02, 2, mk(4'b0001, 1'b0, 4'b0000, 1'b0, 8'h02, 8'hC2, 7'h00));
    chk("irq_clear", {31'd0, bus.h_irq_b}, 32'h1);

    // FIFO reset flag T set then cleared
    access(3'd0, 1'b0, 8'hC0, 2, mk(4'b0001, 1'b0, 4'b0000, 1'b0, 8'hC0, 8'hC2, 7'h40));
    access(3'd0, 1'b0, 8'h40, 2, mk(4'b0001, 1'b0, 4'b0000, 1'b0, 8'h40, 8'hC2, 7'h00));
    access(3'd0, 1'b0, 8'h83, 2, mk(4'b0001, 1'b0, 4'b0000, 1'b0, 8'h83, 8'hC2, 7'h03));

    // Reset asserted inside the ACCESS cycle of a write of C0 to address 0
    @(posedge clk); #2;
    bus.h_addr = 3'd0; bus.h_rdnw = 1'b0; bus.h_wdata = 8'hC0; bus.h_cs_b = 1'b0;
    @(posedge clk); #1;
    chk("mid_ph_select_before", {28'd0, bus.ph_select}, 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_ph_select", {28'd0, bus.ph_select}, 32'h0);
    chk("mid_strobes",   {30'd0, bus.ph_rd, bus.hp_wr}, 32'h0);
    chk("mid_flags",     {25'd0, bus.flags},    32'h00);
    chk("mid_fifo_rst",  {31'd0, bus.fifo_rst}, 32'h0);
    @(posedge clk); #2 bus.h_cs_b = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_flags", {25'd0, bus.flags},   32'h00);
    chk("post_rst_rdata", {24'd0, bus.h_rdata}, 32'h00);

    repeat (4) @(posedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
